// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the shared ALU sequencer: two request ports and the
// common response channel with per-port valid strobes.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             req_valid0;
    logic             req_valid1;
    logic [OPW-1:0]   req_op0;
    logic [OPW-1:0]   req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic             req_s0;
    logic             req_s1;
    logic             req_ready0;
    logic             req_ready1;
    logic             rsp_valid0;
    logic             rsp_valid1;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;

    modport master (
        output req_valid0, req_valid1, req_op0, req_op1,
               req_a0, req_a1, req_b0, req_b1, req_s0, req_s1,
        input  req_ready0, req_ready1, rsp_valid0, rsp_valid1,
               rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid0, req_valid1, req_op0, req_op1,
               req_a0, req_a1, req_b0, req_b1, req_s0, req_s1,
        output req_ready0, req_ready1, rsp_valid0, rsp_valid1,
               rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration and owns the architectural NZCV flags register.
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    alu_share_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic [3:0]       alu_flags_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags_out,
    input  logic             flags_we,
    input  logic [3:0]       flags_wdata,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_last_grant;
    logic             r_win;
    logic             r_s;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic [3:0]       r_rsp_flags;
    logic [3:0]       r_flags;

    logic             w_grant;
    logic             w_win_id;
    logic             w_accept;
    logic             w_exec;

    // On a tie the port that did not win last time is served.
    always_comb begin
        w_grant  = 1'b0;
        w_win_id = 1'b0;
        if (bus.req_valid0 && bus.req_valid1) begin
            w_grant  = 1'b1;
            w_win_id = ~r_last_grant;
        end else if (bus.req_valid0) begin
            w_grant  = 1'b1;
            w_win_id = 1'b0;
        end else if (bus.req_valid1) begin
            w_grant  = 1'b1;
            w_win_id = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_exec         = 1'b0;
        bus.req_ready0 = 1'b0;
        bus.req_ready1 = 1'b0;
        bus.rsp_valid0 = 1'b0;
        bus.rsp_valid1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant && !Reset) begin
                    w_accept       = 1'b1;
                    bus.req_ready0 = ~w_win_id;
                    bus.req_ready1 = w_win_id;
                    w_next         = EXEC;
                end
            end
            EXEC: begin
                w_exec = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                bus.rsp_valid0 = ~r_win & ~Reset;
                bus.rsp_valid1 = r_win & ~Reset;
                w_next         = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // An S-marked EXEC result takes precedence over a same-cycle external write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_grant <= 1'b1;
            r_win        <= 1'b0;
            r_s          <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_data   <= '0;
            r_rsp_flags  <= '0;
            r_flags      <= '0;
        end else begin
            if (w_accept) begin
                r_win        <= w_win_id;
                r_last_grant <= w_win_id;
                r_op         <= w_win_id ? bus.req_op1 : bus.req_op0;
                r_a          <= w_win_id ? bus.req_a1  : bus.req_a0;
                r_b          <= w_win_id ? bus.req_b1  : bus.req_b0;
                r_s          <= w_win_id ? bus.req_s1  : bus.req_s0;
            end
            if (w_exec) begin
                r_rsp_data  <= alu_out;
                r_rsp_flags <= alu_flags_out;
            end
            if (w_exec && r_s) begin
                r_flags <= alu_flags_out;
            end else if (flags_we) begin
                r_flags <= flags_wdata;
            end
        end
    end

    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_op        = r_op;
    assign alu_flags_in  = r_flags;
    assign flags         = r_flags;
    assign busy          = (r_state != IDLE);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_flags = r_rsp_flags;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a stub adder ALU that always
// reports flags 4'b1010.
module tb_alu_share_ctrl;

    logic        Clk;
    logic        Reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags_out;
    logic        flags_we;
    logic [3:0]  flags_wdata;
    logic [3:0]  flags;
    logic        busy;

    alu_share_ctrl_if #(.WIDTH(32), .OPW(5)) bus ();

    alu_share_ctrl #(.WIDTH(32), .OPW(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .bus           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_flags_in  (alu_flags_in),
        .alu_out       (alu_out),
        .alu_flags_out (alu_flags_out),
        .flags_we      (flags_we),
        .flags_wdata   (flags_wdata),
        .flags         (flags),
        .busy          (busy)
    );

    assign alu_out       = alu_a + alu_b;
    assign alu_flags_out = 4'b1010;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic [3:0]  fl;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rsp_valid must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (bus.rsp_valid0 || bus.rsp_valid1) begin
            if (bus.rsp_valid0 && bus.rsp_valid1) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_both: both rsp_valid high at %0t", $time);
            end else if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: port %0d data 0x%0h, expected no response at %0t",
                         bus.rsp_valid1, bus.rsp_data, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_port",  32'(bus.rsp_valid1), 32'(e.port));
                check("rsp_data",  bus.rsp_data, e.data);
                check("rsp_flags", 32'(bus.rsp_flags), 32'(e.fl));
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input bit port, input bit v, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input bit s);
        if (port) begin
            bus.req_valid1 = v; bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_s1 = s;
        end else begin
            bus.req_valid0 = v; bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_s0 = s;
        end
    endtask

    // Returns at posedge+1 of the EXEC cycle that follows the accept.
    task automatic issue(input bit port, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit s, input bit hold);
        bit ok;
        tick();
        set_req(port, 1'b1, op, a, b, s);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (port ? bus.req_ready1 : bus.req_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        tick();
        if (!hold) begin
            if (port) bus.req_valid1 = 1'b0;
            else      bus.req_valid0 = 1'b0;
        end
    endtask

    task automatic wait_idle;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    int acc_port[4];
    int acc_cyc[4];
    int na;
    int cyc;

    initial begin
        Reset       = 1'b1;
        flags_we    = 1'b0;
        flags_wdata = 4'b0000;
        set_req(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        set_req(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        Reset = 1'b0;

        @(negedge Clk);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_flags",    32'(flags), 32'd0);
        check("rst_alu_a",    alu_a, 32'd0);
        check("rst_alu_op",   32'(alu_op), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_flg",  32'(bus.rsp_flags), 32'd0);
        check("rst_rsp_v0",   32'(bus.rsp_valid0), 32'd0);

        // Single request on port 0, s=0
        sbq.push_back('{1'b0, 32'd8, 4'b1010});
        issue(1'b0, 5'd1, 32'd5, 32'd3, 1'b0, 1'b0);
        @(negedge Clk);
        check("t1_alu_a",  alu_a, 32'd5);
        check("t1_alu_b",  alu_b, 32'd3);
        check("t1_alu_op", 32'(alu_op), 32'd1);
        check("t1_busy",   32'(busy), 32'd1);
        @(negedge Clk);
        check("t1_rsp_v0", 32'(bus.rsp_valid0), 32'd1);
        wait_idle();
        check("t1_flags",  32'(flags), 32'd0);

        // Port 1 with s=1 updates flags after EXEC
        sbq.push_back('{1'b1, 32'd2, 4'b1010});
        issue(1'b1, 5'd2, 32'd1, 32'd1, 1'b1, 1'b0);
        @(negedge Clk);
        check("t2_flags_exec", 32'(flags), 32'd0);
        check("t2_fin_exec",   32'(alu_flags_in), 32'd0);
        @(negedge Clk);
        check("t2_rsp_v1", 32'(bus.rsp_valid1), 32'd1);
        check("t2_flags",  32'(flags), 32'hA);
        wait_idle();

        // External write while idle
        tick();
        flags_we = 1'b1; flags_wdata = 4'b0000;
        tick();
        flags_we = 1'b0;
        @(negedge Clk);
        check("we_idle_flags", 32'(flags), 32'd0);

        // Collision: s=1 result beats the external write
        sbq.push_back('{1'b0, 32'd4, 4'b1010});
        issue(1'b0, 5'd3, 32'd2, 32'd2, 1'b1, 1'b0);
        flags_we = 1'b1; flags_wdata = 4'b0101;
        tick();
        flags_we = 1'b0;
        @(negedge Clk);
        check("t4_s_wins", 32'(flags), 32'hA);
        wait_idle();

        // Collision: s=0 lets the external write through, in-flight op sees old value
        sbq.push_back('{1'b1, 32'd7, 4'b1010});
        issue(1'b1, 5'd4, 32'd3, 32'd4, 1'b0, 1'b0);
        flags_we = 1'b1; flags_wdata = 4'b0101;
        @(negedge Clk);
        check("t4_fin_pre", 32'(alu_flags_in), 32'hA);
        tick();
        flags_we = 1'b0;
        @(negedge Clk);
        check("t4_we_wins", 32'(flags), 32'h5);
        check("t4_fin_post", 32'(alu_flags_in), 32'h5);
        wait_idle();

        // Reset during EXEC aborts; held request is accepted again
        issue(1'b0, 5'd5, 32'd6, 32'd6, 1'b1, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        check("t5_busy",   32'(busy), 32'd0);
        check("t5_flags",  32'(flags), 32'd0);
        check("t5_rsp_v0", 32'(bus.rsp_valid0), 32'd0);
        check("t5_ready0", 32'(bus.req_ready0), 32'd1);
        sbq.push_back('{1'b0, 32'd12, 4'b1010});
        tick();
        bus.req_valid0 = 1'b0;
        wait_idle();

        // Back-pressure: port 0 waits while port 1 is in flight
        sbq.push_back('{1'b1, 32'd30, 4'b1010});
        sbq.push_back('{1'b0, 32'd9, 4'b1010});
        issue(1'b1, 5'd6, 32'd10, 32'd20, 1'b0, 1'b0);
        set_req(1'b0, 1'b1, 5'd7, 32'd4, 32'd5, 1'b0);
        @(negedge Clk);
        check("t6_rdy_exec", 32'(bus.req_ready0), 32'd0);
        tick();
        @(negedge Clk);
        check("t6_rdy_resp", 32'(bus.req_ready0), 32'd0);
        tick();
        @(negedge Clk);
        check("t6_rdy_idle", 32'(bus.req_ready0), 32'd1);
        tick();
        bus.req_valid0 = 1'b0;
        @(negedge Clk);
        check("t6_rdy_once", 32'(bus.req_ready0), 32'd0);
        check("t6_busy",     32'(busy), 32'd1);
        wait_idle();

        // Contention from reset: 0,1,0,1 spaced 3 cycles
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sbq.push_back('{1'b0, 32'd11, 4'b1010});
        sbq.push_back('{1'b1, 32'd22, 4'b1010});
        sbq.push_back('{1'b0, 32'd11, 4'b1010});
        sbq.push_back('{1'b1, 32'd22, 4'b1010});
        set_req(1'b0, 1'b1, 5'd8, 32'd10, 32'd1, 1'b0);
        set_req(1'b1, 1'b1, 5'd9, 32'd20, 32'd2, 1'b0);
        na  = 0;
        cyc = 0;
        for (int i = 0; i < 30 && na < 4; i++) begin
            @(negedge Clk);
            cyc++;
            if (bus.req_ready0 && bus.req_ready1) begin
                n_tests++;
                n_fail++;
                $display("FAIL t3_both_ready: both ready high at %0t", $time);
            end
            if (bus.req_ready0 || bus.req_ready1) begin
                acc_port[na] = bus.req_ready1 ? 1 : 0;
                acc_cyc[na]  = cyc;
                na++;
            end
        end
        tick();
        bus.req_valid0 = 1'b0;
        bus.req_valid1 = 1'b0;
        check("t3_accepts", 32'(na), 32'd4);
        if (na == 4) begin
            check("t3_grant0", 32'(acc_port[0]), 32'd0);
            check("t3_grant1", 32'(acc_port[1]), 32'd1);
            check("t3_grant2", 32'(acc_port[2]), 32'd0);
            check("t3_grant3", 32'(acc_port[3]), 32'd1);
            check("t3_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("t3_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("t3_gap3", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
        end
        wait_idle();
        tick();
        tick();
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational ARM_ALU instance between two requesters (port 0: execute stage, port 1: address/auxiliary unit).
- Accepts one operation at a time and drives the ALU operand, opcode and flag-input ports from registered copies.
- Captures Out/FLAGS_OUT and returns them to the winning requester.
- Owns the architectural NZCV flags register, updated only for S-marked operations or by an explicit external write.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 5, ALU opcode width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid0 / req_valid1  in  1  requester n has an operation pending; held until accepted.
- req_op0 / req_op1  in  OPW  opcode for requester n.
- req_a0 / req_a1, req_b0 / req_b1  in  WIDTH  operands for requester n.
- req_s0 / req_s1  in  1  operation updates the flags register.
- req_ready0 / req_ready1  out  1  one-cycle accept pulse.
- rsp_valid0 / rsp_valid1  out  1  one-cycle result-valid pulse.
- rsp_data  out  WIDTH  result; valid only when a rsp_valid is high.
- rsp_flags  out  4  ALU flag outputs for this op, {N,Z,C,V}.
- alu_a, alu_b  out  WIDTH  to ALU A, B.
- alu_op  out  OPW  to ALU OP.
- alu_flags_in  out  4  to ALU FLAGS (current flags register).
- alu_out  in  WIDTH  from ALU Out.
- alu_flags_out  in  4  from ALU FLAGS_OUT.
- flags_we  in  1  external flags write (MSR-style).
- flags_wdata  in  4  external flags value.
- flags  out  4  architectural flags register {N,Z,C,V}.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values (synchronous): state=IDLE; all ready and rsp_valid outputs 0; rsp_data=0; rsp_flags=0; flags=0; latched op/a/b/s=0, so alu_a/alu_b/alu_op=0; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the port that is not last_grant (round-robin).
  - On grant: pulse that port's req_ready for this cycle; latch op/a/b/s and the winner id; set last_grant=winner; go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - ALU inputs are driven from latched registers; alu_flags_in = flags.
  - On the clock edge: rsp_data <= alu_out, rsp_flags <= alu_flags_out.
  - If latched s=1: flags <= alu_flags_out. Go to RESP.
- RESP: assert the winner's rsp_valid for exactly one cycle; go to IDLE.
- Latency: accept at cycle T (ready high), rsp_valid at T+2. Maximum throughput is one op per 3 cycles; the next accept is possible at T+3.
- req_ready is never high outside IDLE; requests arriving while busy wait with valid held.
- rsp_data and rsp_flags hold their last values until the next EXEC.
- Flags write priority in the same cycle: an EXEC update with s=1 wins and flags_we is dropped. Otherwise flags_we writes flags_wdata in any state.
- A flags change made by flags_we during EXEC (s=0) is visible on alu_flags_in the next cycle only; the in-flight op uses the pre-write value.
- Reset mid-operation aborts the transaction: no rsp_valid is issued, flags keep no partial update, state returns to IDLE.
- Requesters must re-present a dropped request after reset.
- Deasserting req_valid before acceptance is legal; that request is simply not granted.

Test Plan (the bench uses a stub ALU: alu_out = alu_a + alu_b, alu_flags_out = 4'b1010):
1. Single request: req0 with a=5, b=3, s=0 at cycle 1 -> req_ready0 high cycle 1, alu_a=5/alu_b=3 in cycle 2, rsp_valid0 high cycle 3 with rsp_data=8, rsp_flags=4'b1010, flags stays 0.
2. S update: req1 with a=1, b=1, s=1 -> rsp_valid1 two cycles after accept, rsp_data=2, flags=4'b1010 from the cycle after EXEC.
3. Contention: both valid continuously from reset -> grants alternate 0,1,0,1 with accepts spaced 3 cycles apart; each rsp_valid goes to the correct port.
4. Flags collision: flags_we=1, flags_wdata=4'b0101 in the EXEC cycle of an s=1 op -> flags=4'b1010. The same write with an s=0 op -> flags=4'b0101.
5. Reset mid-op: assert Reset in the EXEC cycle -> no rsp_valid, flags=0, busy=0 the next cycle, req_ready0 pulses again if req_valid0 is still held.
6. Back-pressure: req0 valid while busy -> req_ready0 stays 0 until state is IDLE, then pulses once.
